// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: drives the IF PC, picks the next PC from the BTB prediction,
// holds fetched words across stalls, redirects on MEM-stage mispredicts and drives BTB maintenance.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0060,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 imem_resp,
   input  logic [31:0]          imem_rdata,
   input  logic                 stall_in,
   input  logic                 btb_hit,
   input  logic                 btb_prediction,
   input  logic [31:0]          btb_target,
   input  logic                 btb_is_jal,
   input  logic                 mem_br_valid,
   input  logic [31:0]          mem_pc,
   input  logic                 mem_is_jal,
   input  logic                 mem_pred_taken,
   input  logic [31:0]          mem_pred_tgt,
   input  logic                 mem_btb_hit,
   input  logic                 mem_taken,
   input  logic [31:0]          mem_target,
   output logic [31:0]          if_pc,
   output logic                 imem_read,
   output logic                 if_valid,
   output logic [31:0]          if_instr,
   output logic                 if_pred_taken,
   output logic [31:0]          if_pred_tgt,
   output logic                 flush,
   output logic                 btb_replace,
   output logic                 btb_update,
   output logic                 btb_result,
   output logic [31:0]          btb_target_in,
   output logic [CNT_WIDTH-1:0] br_count,
   output logic [CNT_WIDTH-1:0] mispred_count
);

   typedef enum logic [1:0] {
      ST_REQ     = 2'd0,
      ST_HOLD    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t      state_r, state_nx_s;
   logic [31:0] addr_r, addr_nx_s;
   logic [31:0] redir_r, redir_nx_s;
   logic [31:0] buf_instr_r, buf_instr_nx_s;
   logic        buf_pred_r, buf_pred_nx_s;
   logic [31:0] buf_next_r, buf_next_nx_s;

   logic        pred_taken_s;
   logic [31:0] next_pc_s;
   logic        mispredict_s;
   logic [31:0] redirect_pc_s;

   assign pred_taken_s  = btb_hit & (btb_is_jal | btb_prediction);
   assign next_pc_s     = pred_taken_s ? btb_target : (addr_r + 32'd4);
   assign mispredict_s  = mem_br_valid & ((mem_pred_taken != mem_taken) |
                                          (mem_taken & (mem_pred_tgt != mem_target)));
   assign redirect_pc_s = mem_taken ? mem_target : (mem_pc + 32'd4);

   assign if_pc         = addr_r;
   assign flush         = mispredict_s;
   assign btb_replace   = mem_br_valid & ~mem_btb_hit & mem_taken;
   assign btb_update    = mem_br_valid & mem_btb_hit & ~mem_is_jal;
   assign btb_result    = mem_taken;
   assign btb_target_in = mem_target;

   // Next-state, next-address and fetch-output decode; imem address only moves on a response or from HOLD.
   always_comb begin
      state_nx_s     = state_r;
      addr_nx_s      = addr_r;
      redir_nx_s     = redir_r;
      buf_instr_nx_s = buf_instr_r;
      buf_pred_nx_s  = buf_pred_r;
      buf_next_nx_s  = buf_next_r;
      imem_read      = 1'b1;
      if_valid       = 1'b0;
      if_instr       = imem_rdata;
      if_pred_taken  = pred_taken_s;
      if_pred_tgt    = next_pc_s;
      case (state_r)
         ST_REQ: begin
            if (imem_resp) begin
               if (mispredict_s) begin
                  addr_nx_s = redirect_pc_s;
               end else if (stall_in) begin
                  buf_instr_nx_s = imem_rdata;
                  buf_pred_nx_s  = pred_taken_s;
                  buf_next_nx_s  = next_pc_s;
                  state_nx_s     = ST_HOLD;
               end else begin
                  if_valid  = 1'b1;
                  addr_nx_s = next_pc_s;
               end
            end else if (mispredict_s) begin
               redir_nx_s = redirect_pc_s;
               state_nx_s = ST_DISCARD;
            end else begin
               state_nx_s = ST_REQ;
            end
         end
         ST_HOLD: begin
            imem_read     = 1'b0;
            if_instr      = buf_instr_r;
            if_pred_taken = buf_pred_r;
            if_pred_tgt   = buf_next_r;
            // A mispredict kills the held word even while downstream is stalled.
            if (mispredict_s) begin
               buf_instr_nx_s = 32'h0000_0000;
               buf_pred_nx_s  = 1'b0;
               buf_next_nx_s  = 32'h0000_0000;
               addr_nx_s      = redirect_pc_s;
               state_nx_s     = ST_REQ;
            end else begin
               if_valid = 1'b1;
               if (!stall_in) begin
                  addr_nx_s  = buf_next_r;
                  state_nx_s = ST_REQ;
               end else begin
                  state_nx_s = ST_HOLD;
               end
            end
         end
         ST_DISCARD: begin
            if (imem_resp) begin
               addr_nx_s  = mispredict_s ? redirect_pc_s : redir_r;
               state_nx_s = ST_REQ;
            end else if (mispredict_s) begin
               redir_nx_s = redirect_pc_s;
            end else begin
               state_nx_s = ST_DISCARD;
            end
         end
         default: begin
            state_nx_s = ST_REQ;
            addr_nx_s  = RESET_PC;
         end
      endcase
   end

   // Fetch state, address, pending redirect and hold buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_REQ;
         addr_r      <= RESET_PC;
         redir_r     <= 32'h0000_0000;
         buf_instr_r <= 32'h0000_0000;
         buf_pred_r  <= 1'b0;
         buf_next_r  <= 32'h0000_0000;
      end else begin
         state_r     <= state_nx_s;
         addr_r      <= addr_nx_s;
         redir_r     <= redir_nx_s;
         buf_instr_r <= buf_instr_nx_s;
         buf_pred_r  <= buf_pred_nx_s;
         buf_next_r  <= buf_next_nx_s;
      end
   end

   // Saturating performance counters for resolved branches and mispredictions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count      <= {CNT_WIDTH{1'b0}};
         mispred_count <= {CNT_WIDTH{1'b0}};
      end else begin
         if (mem_br_valid && (br_count != CNT_MAX)) begin
            br_count <= br_count + CNT_ONE;
         end else begin
            br_count <= br_count;
         end
         if (mispredict_s && (mispred_count != CNT_MAX)) begin
            mispred_count <= mispred_count + CNT_ONE;
         end else begin
            mispred_count <= mispred_count;
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level fetch model.
module tb_fetch_pc_unit;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          imem_resp, stall_in, btb_hit, btb_prediction, btb_is_jal;
   logic [31:0]   imem_rdata, btb_target;
   logic          mem_br_valid, mem_is_jal, mem_pred_taken, mem_btb_hit, mem_taken;
   logic [31:0]   mem_pc, mem_pred_tgt, mem_target;
   logic [31:0]   if_pc, if_instr, if_pred_tgt, btb_target_in;
   logic          imem_read, if_valid, if_pred_taken, flush, btb_replace, btb_update, btb_result;
   logic [CW-1:0] br_count, mispred_count;

   int errors = 0;
   int checks = 0;

   // Model: current fetch address, whether a word is parked, whether a stale response is owed.
   logic [31:0] m_pc, m_redir, b_instr, b_next;
   bit          m_hold, m_disc, b_pt;
   int          m_br, m_mp;

   always #5 clk = ~clk;

   fetch_pc_unit #(.RESET_PC(32'h0000_0060), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .stall_in(stall_in), .btb_hit(btb_hit), .btb_prediction(btb_prediction),
      .btb_target(btb_target), .btb_is_jal(btb_is_jal), .mem_br_valid(mem_br_valid),
      .mem_pc(mem_pc), .mem_is_jal(mem_is_jal), .mem_pred_taken(mem_pred_taken),
      .mem_pred_tgt(mem_pred_tgt), .mem_btb_hit(mem_btb_hit), .mem_taken(mem_taken),
      .mem_target(mem_target), .if_pc(if_pc), .imem_read(imem_read), .if_valid(if_valid),
      .if_instr(if_instr), .if_pred_taken(if_pred_taken), .if_pred_tgt(if_pred_tgt),
      .flush(flush), .btb_replace(btb_replace), .btb_update(btb_update),
      .btb_result(btb_result), .btb_target_in(btb_target_in), .br_count(br_count),
      .mispred_count(mispred_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      m_pc = 32'h60; m_redir = 32'h0; m_hold = 0; m_disc = 0;
      b_instr = 32'h0; b_next = 32'h0; b_pt = 0; m_br = 0; m_mp = 0;
   endtask

   task automatic drive_idle();
      imem_resp = 0; stall_in = 0; btb_hit = 0; btb_prediction = 0; btb_is_jal = 0;
      btb_target = 32'h0; mem_br_valid = 0; mem_pc = 32'h0; mem_is_jal = 0;
      mem_pred_taken = 0; mem_pred_tgt = 32'h0; mem_btb_hit = 0; mem_taken = 0;
      mem_target = 32'h0;
   endtask

   // Compare all outputs against the model for this cycle, then advance the model.
   task automatic settle_check();
      bit          ptk, mp, e_valid, e_pt;
      logic [31:0] npc, rpc, e_instr, e_tgt;
      imem_rdata = word_of(m_pc);
      #1;
      ptk = btb_hit && (btb_is_jal || btb_prediction);
      npc = ptk ? btb_target : m_pc + 32'd4;
      mp  = mem_br_valid && ((mem_pred_taken != mem_taken) ||
                             (mem_taken && mem_pred_tgt != mem_target));
      rpc = mem_taken ? mem_target : mem_pc + 32'd4;
      if (m_hold) begin
         e_valid = !mp; e_instr = b_instr; e_pt = b_pt; e_tgt = b_next;
      end else if (m_disc) begin
         e_valid = 0; e_instr = 32'h0; e_pt = 0; e_tgt = 32'h0;
      end else begin
         e_valid = imem_resp && !mp && !stall_in;
         e_instr = word_of(m_pc); e_pt = ptk; e_tgt = npc;
      end
      chk("if_pc", if_pc, m_pc);
      chk("imem_read", imem_read, !m_hold);
      chk("if_valid", if_valid, e_valid);
      if (e_valid) begin
         chk("if_instr", if_instr, e_instr);
         chk("if_pred_taken", if_pred_taken, e_pt);
         chk("if_pred_tgt", if_pred_tgt, e_tgt);
      end
      chk("flush", flush, mp);
      chk("btb_replace", btb_replace, mem_br_valid && !mem_btb_hit && mem_taken);
      chk("btb_update", btb_update, mem_br_valid && mem_btb_hit && !mem_is_jal);
      chk("btb_result", btb_result, mem_taken);
      chk("btb_target_in", btb_target_in, mem_target);
      chk("br_count", br_count, m_br);
      chk("mispred_count", mispred_count, m_mp);
      if (m_hold) begin
         if (mp) begin m_hold = 0; m_pc = rpc; end
         else if (!stall_in) begin m_hold = 0; m_pc = b_next; end
      end else if (m_disc) begin
         if (imem_resp) begin m_disc = 0; m_pc = mp ? rpc : m_redir; end
         else if (mp) m_redir = rpc;
      end else if (imem_resp) begin
         if (mp) m_pc = rpc;
         else if (stall_in) begin m_hold = 1; b_instr = word_of(m_pc); b_pt = ptk; b_next = npc; end
         else m_pc = npc;
      end else if (mp) begin
         m_disc = 1; m_redir = rpc;
      end
      if (mem_br_valid && m_br < (2**CW - 1)) m_br++;
      if (mp && m_mp < (2**CW - 1)) m_mp++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive_idle();
      imem_rdata = 32'h0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      // Reset state
      settle_check();
      chk("rst_if_pc", if_pc, 32'h60);
      chk("rst_imem_read", imem_read, 1'b1);
      chk("rst_if_valid", if_valid, 1'b0);
      chk("rst_flush", flush, 1'b0);
      chk("rst_br_count", br_count, 0);
      tick();
      // Sequential fetch, no BTB hit
      imem_resp = 1;
      for (int i = 0; i < 4; i++) begin
         settle_check();
         if (i < 3) begin
            chk("seq_if_pc", if_pc, 32'h60 + 32'(4 * i));
            chk("seq_if_valid", if_valid, 1'b1);
         end
         tick();
      end
      // Predicted-taken redirect at 0x70
      btb_hit = 1; btb_prediction = 1; btb_target = 32'h200;
      settle_check();
      chk("pred_if_pc", if_pc, 32'h70);
      chk("pred_taken", if_pred_taken, 1'b1);
      chk("pred_tgt", if_pred_tgt, 32'h200);
      tick();
      drive_idle();
      // Stall: response captured, then held for three cycles
      imem_resp = 1; stall_in = 1;
      settle_check();
      chk("pred_next_pc", if_pc, 32'h200);
      tick();
      imem_resp = 0;
      for (int i = 0; i < 3; i++) begin
         settle_check();
         chk("hold_valid", if_valid, 1'b1);
         chk("hold_instr", if_instr, word_of(32'h200));
         chk("hold_read", imem_read, 1'b0);
         chk("hold_pc", if_pc, 32'h200);
         tick();
      end
      stall_in = 0;
      settle_check();
      chk("release_valid", if_valid, 1'b1);
      tick();
      // Mispredict with response in the same cycle
      imem_resp = 1; mem_br_valid = 1; mem_pred_taken = 0; mem_taken = 1;
      mem_target = 32'h400; mem_btb_hit = 0; mem_pc = 32'h1F0;
      settle_check();
      chk("mp_if_pc", if_pc, 32'h204);
      chk("mp_flush", flush, 1'b1);
      chk("mp_replace", btb_replace, 1'b1);
      chk("mp_drop", if_valid, 1'b0);
      tick();
      drive_idle();
      settle_check();
      chk("mp_redirect", if_pc, 32'h400);
      chk("mp_count", mispred_count, 1);
      chk("br_count1", br_count, 1);
      tick();
      // Mispredict while the response is still outstanding
      mem_br_valid = 1; mem_pred_taken = 0; mem_taken = 1; mem_target = 32'h500;
      mem_btb_hit = 1; mem_is_jal = 1;
      settle_check();
      chk("disc_flush", flush, 1'b1);
      tick();
      drive_idle();
      settle_check();
      chk("disc_addr_held", if_pc, 32'h400);
      chk("disc_read", imem_read, 1'b1);
      chk("disc_valid", if_valid, 1'b0);
      tick();
      imem_resp = 1;
      settle_check();
      chk("disc_drop", if_valid, 1'b0);
      tick();
      drive_idle();
      settle_check();
      chk("disc_redirect", if_pc, 32'h500);
      chk("mp_count2", mispred_count, 2);
      tick();
      // Predicted taken, actually not taken, BTB hit
      mem_br_valid = 1; mem_btb_hit = 1; mem_is_jal = 0; mem_pred_taken = 1;
      mem_pred_tgt = 32'h100; mem_taken = 0; mem_target = 32'h100; mem_pc = 32'h80;
      settle_check();
      chk("nt_update", btb_update, 1'b1);
      chk("nt_result", btb_result, 1'b0);
      chk("nt_replace", btb_replace, 1'b0);
      chk("nt_flush", flush, 1'b1);
      tick();
      drive_idle();
      imem_resp = 1;
      settle_check();
      tick();
      drive_idle();
      settle_check();
      chk("nt_redirect", if_pc, 32'h84);
      tick();
      // Counter saturation burst
      for (int i = 0; i < 20; i++) begin
         imem_resp = 1; mem_br_valid = 1; mem_pred_taken = 1; mem_taken = 0;
         mem_pc = 32'h1000 + 32'(8 * i);
         settle_check();
         tick();
      end
      drive_idle();
      settle_check();
      chk("sat_br", br_count, 4'hF);
      chk("sat_mp", mispred_count, 4'hF);
      tick();
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         stall_in       = ($urandom % 4) == 0;
         imem_resp      = !m_hold && (($urandom % 3) != 0);
         btb_hit        = $urandom % 2;
         btb_prediction = $urandom % 2;
         btb_is_jal     = ($urandom % 4) == 0;
         btb_target     = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
         mem_br_valid   = ($urandom % 5) == 0;
         mem_pc         = 32'($urandom) & 32'hFFFF_FFFC;
         mem_is_jal     = $urandom % 2;
         mem_pred_taken = $urandom % 2;
         mem_taken      = $urandom % 2;
         mem_btb_hit    = $urandom % 2;
         mem_pred_tgt   = ($urandom % 2) ? 32'h400 : 32'h404;
         mem_target     = ($urandom % 2) ? 32'h400 : 32'h404;
         settle_check();
         tick();
      end
      // Asynchronous reset mid-fetch; a response during reset is ignored
      drive_idle();
      imem_resp = 1; stall_in = 1;
      settle_check();
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_if_pc", if_pc, 32'h60);
      chk("arst_br", br_count, 0);
      chk("arst_mp", mispred_count, 0);
      chk("arst_read", imem_read, 1'b1);
      tick();
      rst_n = 1'b1;
      model_reset();
      stall_in = 0;
      settle_check();
      chk("post_rst_valid", if_valid, 1'b1);
      chk("post_rst_instr", if_instr, word_of(32'h60));
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
